game_field_server: RTL and testbench
====================================

GAME_FIELD_SERVER -- requirements
Module: game_field_server

Interface
REQ-001 SHALL have parameter WIDTH, default 64: playfield width in grid cells.
REQ-002 SHALL have parameter GAME_HEIGHT, default 44: playfield height in grid cells.
REQ-003 SHALL have parameter TANK_SIZE, default 3: tank footprint edge in cells.
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 SHALL have port i_state, input, 2: game state; 2'b01 is game.
REQ-007 SHALL have port i_buzy, input, 1: display is scanning active lines.
REQ-008 SHALL have port i_request_x, input, 6: requested cell column.
REQ-009 SHALL have port i_request_y, input, 6: requested cell row.
REQ-010 SHALL have ports o_is_wall, o_is_tank_1, o_is_tank_2, o_is_shell_1 and o_is_shell_2, output, 1 each: occupancy of the requested cell.
REQ-011 SHALL have port i_upd_valid, input, 1: update request.
REQ-012 SHALL have port o_upd_ready, output, 1: update accepted this cycle.
REQ-013 SHALL have port i_upd_sel, input, 3: update target; 0 tank1, 1 tank2, 2 shell1, 3 shell2, 4 wall set, 5 wall clear, 6-7 reserved.
REQ-014 SHALL have ports i_upd_x and i_upd_y, input, 6 each: update coordinates.
REQ-015 SHALL have port i_upd_live, input, 1: shell active flag, used for sel 2 and 3 only.
REQ-016 SHALL have port o_init_done, output, 1: high while in state SERVE.

Function
REQ-017 SHALL implement FSM states INIT and SERVE.
REQ-018 SHALL write, in INIT, one wall row per cycle for rows 0..GAME_HEIGHT-1 (44 cycles) using row counter r.
REQ-019 SHALL write rows 0 and GAME_HEIGHT-1 as all ones and every other row with only bits 0 and WIDTH-1 set.
REQ-020 SHALL go from INIT to SERVE on the cycle after writing row GAME_HEIGHT-1.
REQ-021 SHALL register prev_state each cycle.
REQ-022 SHALL enter INIT with r=0, from any state, when i_state==2'b01 and prev_state!=2'b01.
REQ-023 SHALL restore tank and shell registers to their reset values on that INIT entry.
REQ-024 SHALL make lookup outputs valid exactly 1 cycle after request coordinates are presented.
REQ-025 SHALL register lookup outputs and recompute them every cycle.
REQ-026 SHALL set o_is_wall = wall[y][x].
REQ-027 SHALL set o_is_tank_N = (tx <= x <= tx+TANK_SIZE-1) && (ty <= y <= ty+TANK_SIZE-1).
REQ-028 SHALL compute tank bounds with 7-bit unsigned arithmetic so that no wrap-around occurs.
REQ-029 SHALL set o_is_shell_N = live_N && x==sx_N && y==sy_N.
REQ-030 SHALL drive all five lookup outputs 0 on the cycle after a request with i_request_y >= GAME_HEIGHT.
REQ-031 SHALL drive all five lookup outputs 0 while in INIT.
REQ-032 SHALL drive o_upd_ready = (state==SERVE) && !i_buzy, combinationally.
REQ-033 SHALL transfer an update when i_upd_valid && o_upd_ready.
REQ-034 SHALL leave all state unchanged when i_upd_valid is high and o_upd_ready is low, so the requester must hold its request.
REQ-035 SHALL make a transferred update visible starting with lookups presented the cycle after transfer.
REQ-036 SHALL make a same-cycle lookup observe the old value (read-before-write).
REQ-037 SHALL have sel 0/1 load tx/ty and sel 2/3 load sx, sy and live.
REQ-038 SHALL have sel 4/5 set/clear wall[i_upd_y][i_upd_x].
REQ-039 SHALL consume an update with i_upd_y >= GAME_HEIGHT without effect.
REQ-040 SHALL consume an update with reserved sel without effect.
REQ-041 SHALL accept a tank update whose footprint exceeds the field; cells beyond the field are never requested.
REQ-042 SHALL NOT let a wall update alter tank or shell state, nor the reverse.
REQ-043 SHALL NOT perform wall updates during INIT (ready is low).

Reset
REQ-044 SHALL, on rst_n low at a clk edge, set state=INIT and r=0.
REQ-045 SHALL set tank1=(2,2) and tank2=(59,39) on reset.
REQ-046 SHALL set shells to live=0, position (0,0) on reset.
REQ-047 SHALL set all lookup outputs to 0 on reset.
REQ-048 SHALL set o_init_done=0 and prev_state=2'b00 on reset.
REQ-049 SHALL NOT reset the wall array directly; INIT rewrites it.
REQ-050 SHALL restart INIT from row 0 when reset is asserted during INIT.

Verification
REQ-051 SHALL cover: reset release with i_state=01 -> o_init_done rises 44 cycles later; request (0,5) -> wall=1; request (10,10) -> wall=0; request (63,43) -> wall=1.
REQ-052 SHALL cover: after init, request (3,3) then (4,2) then (5,3) -> o_is_tank_1 = 1,1,0 on successive cycles; request (61,41) -> o_is_tank_2=1.
REQ-053 SHALL cover: i_buzy=1 with valid sel=4 (20,20) -> ready=0 and wall unchanged; drop i_buzy -> ready=1 and the transfer happens; next-cycle request (20,20) -> wall=1.
REQ-054 SHALL cover: a same-cycle transfer sel=5 (0,10) with lookup (0,10) -> output 1 that cycle, 0 for a lookup one cycle later.
REQ-055 SHALL cover: sel=2 (30,30) live=1 -> shell1 hit at (30,30) only; then live=0 -> miss; request y=44 -> all outputs 0.
REQ-056 SHALL cover: i_state 01 -> 00 -> 01 mid-game -> init_done drops, tanks return to reset positions, and a previously set wall at (20,20) reads 0 after re-init.

Source files
------------

// File: rtl/game_field_server.sv
// rtl/game_field_server.sv - playfield occupancy server: wall bitmap, two tanks, two shells
// Registered cell lookups, plus a ready/valid update port that is open only while serving and the display is idle.
module game_field_server #(
   parameter int WIDTH       = 64,
   parameter int GAME_HEIGHT = 44,
   parameter int TANK_SIZE   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_state,
   input  logic       i_buzy,
   input  logic [5:0] i_request_x,
   input  logic [5:0] i_request_y,
   output logic       o_is_wall,
   output logic       o_is_tank_1,
   output logic       o_is_tank_2,
   output logic       o_is_shell_1,
   output logic       o_is_shell_2,
   input  logic       i_upd_valid,
   output logic       o_upd_ready,
   input  logic [2:0] i_upd_sel,
   input  logic [5:0] i_upd_x,
   input  logic [5:0] i_upd_y,
   input  logic       i_upd_live,
   output logic       o_init_done
);

   typedef enum logic {INIT, SERVE} state_t;

   localparam logic [5:0] LAST_ROW = 6'(GAME_HEIGHT - 1);

   state_t           state, state_d;
   logic [5:0]       r, r_d, row;
   logic [1:0]       prev_state;
   logic             enter, row_we, xfer, blank;
   logic [WIDTH-1:0] row_data;
   logic [WIDTH-1:0] wall [GAME_HEIGHT];
   logic [5:0]       tx1, ty1, tx2, ty2, sx1, sy1, sx2, sy2;
   logic             live1, live2;

   assign enter       = (i_state == 2'b01) && (prev_state != 2'b01);
   assign o_upd_ready = (state == SERVE) && !i_buzy;
   assign o_init_done = (state == SERVE);
   // A game restart in the same cycle takes priority over any pending update.
   assign xfer        = i_upd_valid && o_upd_ready && !enter && (i_upd_y < 6'(GAME_HEIGHT));
   assign blank       = (state == INIT) || (state_d == INIT) || (i_request_y >= 6'(GAME_HEIGHT));

   // The entry cycle itself writes row 0, so a full init always takes GAME_HEIGHT cycles.
   always_comb begin
      state_d = state;
      r_d     = r;
      row     = '0;
      row_we  = 1'b0;
      if (enter) begin
         state_d = INIT;
         row_we  = 1'b1;
         r_d     = 6'd1;
      end else if (state == INIT) begin
         row_we = 1'b1;
         row    = r;
         r_d    = r + 6'd1;
         if (r == LAST_ROW) begin
            state_d = SERVE;
            r_d     = '0;
         end
      end
   end

   always_comb begin
      row_data = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
      if (row == '0 || row == LAST_ROW) row_data = '1;
   end

   function automatic logic in_tank(input logic [5:0] tx, input logic [5:0] ty,
                                    input logic [5:0] x, input logic [5:0] y);
      return ({1'b0, x} >= {1'b0, tx}) && ({1'b0, x} <= {1'b0, tx} + 7'(TANK_SIZE - 1)) &&
             ({1'b0, y} >= {1'b0, ty}) && ({1'b0, y} <= {1'b0, ty} + 7'(TANK_SIZE - 1));
   endfunction

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (row_we)
            wall[row] <= row_data;
         else if (xfer && i_upd_sel == 3'd4)
            wall[i_upd_y][i_upd_x] <= 1'b1;
         else if (xfer && i_upd_sel == 3'd5)
            wall[i_upd_y][i_upd_x] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= INIT;
         r            <= '0;
         prev_state   <= 2'b00;
         tx1 <= 6'd2;  ty1 <= 6'd2;
         tx2 <= 6'd59; ty2 <= 6'd39;
         sx1 <= '0; sy1 <= '0; live1 <= 1'b0;
         sx2 <= '0; sy2 <= '0; live2 <= 1'b0;
         o_is_wall    <= 1'b0;
         o_is_tank_1  <= 1'b0;
         o_is_tank_2  <= 1'b0;
         o_is_shell_1 <= 1'b0;
         o_is_shell_2 <= 1'b0;
      end else begin
         state      <= state_d;
         r          <= r_d;
         prev_state <= i_state;
         if (enter) begin
            tx1 <= 6'd2;  ty1 <= 6'd2;
            tx2 <= 6'd59; ty2 <= 6'd39;
            sx1 <= '0; sy1 <= '0; live1 <= 1'b0;
            sx2 <= '0; sy2 <= '0; live2 <= 1'b0;
         end else if (xfer) begin
            case (i_upd_sel)
               3'd0: begin tx1 <= i_upd_x; ty1 <= i_upd_y; end
               3'd1: begin tx2 <= i_upd_x; ty2 <= i_upd_y; end
               3'd2: begin sx1 <= i_upd_x; sy1 <= i_upd_y; live1 <= i_upd_live; end
               3'd3: begin sx2 <= i_upd_x; sy2 <= i_upd_y; live2 <= i_upd_live; end
               default: ;
            endcase
         end
         o_is_wall    <= !blank && wall[i_request_y][i_request_x];
         o_is_tank_1  <= !blank && in_tank(tx1, ty1, i_request_x, i_request_y);
         o_is_tank_2  <= !blank && in_tank(tx2, ty2, i_request_x, i_request_y);
         o_is_shell_1 <= !blank && live1 && (i_request_x == sx1) && (i_request_y == sy1);
         o_is_shell_2 <= !blank && live2 && (i_request_x == sx2) && (i_request_y == sy2);
      end
   end

endmodule

// File: tb/tb_game_field_server.sv
// tb/tb_game_field_server.sv - scoreboard bench for game_field_server
// Lookup expectations come from a small field model and are queued when each request is driven.
module tb_game_field_server;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_state;
   logic       i_buzy;
   logic [5:0] i_request_x, i_request_y;
   logic       o_is_wall, o_is_tank_1, o_is_tank_2, o_is_shell_1, o_is_shell_2;
   logic       i_upd_valid, o_upd_ready;
   logic [2:0] i_upd_sel;
   logic [5:0] i_upd_x, i_upd_y;
   logic       i_upd_live, o_init_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] exp_q[$];
   string      tag_q[$];

   logic [63:0] mwall [44];
   int          t1x, t1y, t2x, t2y, s1x, s1y, s2x, s2y;
   logic        l1, l2;

   always #5 clk = ~clk;

   game_field_server dut (
      .clk(clk), .rst_n(rst_n), .i_state(i_state), .i_buzy(i_buzy),
      .i_request_x(i_request_x), .i_request_y(i_request_y),
      .o_is_wall(o_is_wall), .o_is_tank_1(o_is_tank_1), .o_is_tank_2(o_is_tank_2),
      .o_is_shell_1(o_is_shell_1), .o_is_shell_2(o_is_shell_2),
      .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready), .i_upd_sel(i_upd_sel),
      .i_upd_x(i_upd_x), .i_upd_y(i_upd_y), .i_upd_live(i_upd_live),
      .o_init_done(o_init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int y = 0; y < 44; y++)
         mwall[y] = (y == 0 || y == 43) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0001;
      t1x = 2;  t1y = 2;  t2x = 59; t2y = 39;
      s1x = 0;  s1y = 0;  s2x = 0;  s2y = 0;
      l1 = 1'b0; l2 = 1'b0;
   endtask

   function automatic logic [4:0] model(input int x, input int y);
      logic w, a, b, c, d;
      if (y >= 44) return 5'b0;
      w = mwall[y][x];
      a = (x >= t1x) && (x <= t1x + 2) && (y >= t1y) && (y <= t1y + 2);
      b = (x >= t2x) && (x <= t2x + 2) && (y >= t2y) && (y <= t2y + 2);
      c = l1 && x == s1x && y == s1y;
      d = l2 && x == s2x && y == s2y;
      return {w, a, b, c, d};
   endfunction

   task automatic model_apply(input int sel, input int x, input int y, input logic live);
      if (y >= 44) return;
      case (sel)
         0: begin t1x = x; t1y = y; end
         1: begin t2x = x; t2y = y; end
         2: begin s1x = x; s1y = y; l1 = live; end
         3: begin s2x = x; s2y = y; l2 = live; end
         4: mwall[y][x] = 1'b1;
         5: mwall[y][x] = 1'b0;
         default: ;
      endcase
   endtask

   // One clock: after the edge, the oldest queued request's lookup is due.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
         chk(tag_q.pop_front(), {o_is_wall, o_is_tank_1, o_is_tank_2, o_is_shell_1, o_is_shell_2},
             exp_q.pop_front());
   endtask

   task automatic push(input int x, input int y, input logic [4:0] e, input string tag);
      i_request_x = 6'(x);
      i_request_y = 6'(y);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic req(input int x, input int y, input string tag);
      push(x, y, model(x, y), tag);
      cyc();
   endtask

   task automatic upd(input int sel, input int x, input int y, input logic live,
                      input int rx, input int ry, input string tag);
      i_upd_valid = 1'b1;
      i_upd_sel   = 3'(sel);
      i_upd_x     = 6'(x);
      i_upd_y     = 6'(y);
      i_upd_live  = live;
      push(rx, ry, model(rx, ry), tag);
      #1;
      chk({tag, "_ready"}, o_upd_ready, 1'b1);
      model_apply(sel, x, y, live);
      cyc();
      i_upd_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; i_state = 2'b01; i_buzy = 1'b0;
      i_request_x = '0; i_request_y = '0;
      i_upd_valid = 1'b0; i_upd_sel = '0; i_upd_x = '0; i_upd_y = '0; i_upd_live = 1'b0;
      model_reset();
      repeat (3) cyc();
      chk("rst_outputs", {o_is_wall, o_is_tank_1, o_is_tank_2, o_is_shell_1, o_is_shell_2}, 5'b0);
      chk("rst_init_done", o_init_done, 1'b0);
      chk("rst_ready", o_upd_ready, 1'b0);

      rst_n = 1'b1;
      for (int k = 1; k <= 44; k++) begin
         cyc();
         if (k == 43) chk("init_done_43", o_init_done, 1'b0);
      end
      chk("init_done_44", o_init_done, 1'b1);

      req(0, 5, "wall_0_5");
      req(10, 10, "wall_10_10");
      req(63, 43, "wall_63_43");
      req(3, 3, "tank1_3_3");
      req(4, 2, "tank1_4_2");
      req(5, 3, "tank1_5_3");
      req(61, 41, "tank2_61_41");

      i_buzy = 1'b1; i_upd_valid = 1'b1; i_upd_sel = 3'd4; i_upd_x = 6'd20; i_upd_y = 6'd20;
      push(20, 20, model(20, 20), "buzy_hold_a");
      #1 chk("buzy_ready", o_upd_ready, 1'b0);
      cyc();
      req(20, 20, "buzy_hold_b");
      i_buzy = 1'b0;
      upd(4, 20, 20, 1'b0, 20, 20, "wall_set_same");
      req(20, 20, "wall_set_after");

      upd(5, 0, 10, 1'b0, 0, 10, "wall_clr_same");
      req(0, 10, "wall_clr_after");

      upd(2, 30, 30, 1'b1, 30, 30, "shell1_set_same");
      req(30, 30, "shell1_hit");
      req(31, 30, "shell1_miss_x");
      req(30, 31, "shell1_miss_y");
      upd(3, 10, 12, 1'b1, 10, 12, "shell2_set_same");
      req(10, 12, "shell2_hit");
      upd(6, 30, 30, 1'b0, 30, 30, "reserved_same");
      req(30, 30, "reserved_noeffect");
      upd(2, 30, 30, 1'b0, 30, 30, "shell1_kill_same");
      req(30, 30, "shell1_dead");
      req(0, 44, "y44_blank");
      req(0, 63, "y63_blank");
      upd(4, 5, 50, 1'b0, 5, 5, "wall_y50_same");
      req(0, 43, "wall_y50_noeffect");
      upd(0, 62, 42, 1'b0, 63, 43, "tank1_edge_same");
      req(63, 43, "tank1_edge_hit");
      req(61, 40, "tank1_edge_miss");
      upd(1, 20, 20, 1'b0, 22, 22, "tank2_move_same");
      req(22, 22, "tank2_over_wall");

      i_state = 2'b00;
      cyc();
      i_state = 2'b01;
      push(20, 20, 5'b0, "init_entry_blank");
      cyc();
      chk("reinit_done_low", o_init_done, 1'b0);
      model_reset();
      push(0, 0, 5'b0, "init_blank");
      for (int k = 2; k <= 44; k++) begin
         cyc();
         if (k == 43) chk("reinit_done_43", o_init_done, 1'b0);
      end
      chk("reinit_done_44", o_init_done, 1'b1);
      req(20, 20, "reinit_wall_20_20");
      req(2, 2, "reinit_tank1");
      req(61, 41, "reinit_tank2");
      req(63, 43, "reinit_corner");
      req(10, 12, "reinit_shell2");
      req(0, 10, "reinit_wall_0_10");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
